dht11_responder: RTL and testbench

Single-wire DHT11 sensor emulator. It is the responder end of the bus that our DHT host controller drives through its tristate pin buffer. It watches the shared data line for a host start pulse, then replies with the DHT11 presence pulse and a 40-bit frame built from four data bytes and their checksum. It sits behind its own TRIS-style pin buffer (DIR/SEND/READ) and is used for board loopback tests and for closed-loop simulation of the host controller.

---
 rtl/dht_pkg.sv | 40 ++++
 rtl/dht_sync.sv | 17 +
 rtl/dht11_responder.sv | 142 ++++++++++++++
 tb/tb_dht11_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// dht_pkg: DHT11 bus constants, FSM state encoding and frame layout
// shared by the responder and the host controller.
package dht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_EOF_LOW
    } dht_state_t;

    localparam int DHT_TICKS_PER_US = 50;
    localparam int DHT_START_MIN_US = 18000;
    localparam int DHT_RESP_WAIT_US = 30;
    localparam int DHT_RESP_LOW_US  = 80;
    localparam int DHT_RESP_HIGH_US = 80;
    localparam int DHT_BIT_LOW_US   = 50;
    localparam int DHT_BIT0_HIGH_US = 27;
    localparam int DHT_BIT1_HIGH_US = 70;

    localparam int DHT_FRAME_W = 40;
    localparam int DHT_CNT_W   = 24;

    // Wire order, MSB first: HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC, checksum.
    function automatic logic [DHT_FRAME_W-1:0] dht_frame(
        input logic [7:0] hum_int,
        input logic [7:0] hum_dec,
        input logic [7:0] temp_int,
        input logic [7:0] temp_dec
    );
        logic [7:0] sum;
        sum = hum_int + hum_dec + temp_int + temp_dec;
        return {hum_int, hum_dec, temp_int, temp_dec, sum};
    endfunction

endpackage

// File: rtl/dht_sync.sv
// dht_sync: 2-flop synchronizer for the bus line; resets to 1 so an idle
// (pulled-up) line never looks like a start request.
module dht_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) {q_o, meta_q} <= 2'b11;
        else       {q_o, meta_q} <= {meta_q, d_i};
    end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator; detects a host start pulse and
// answers with the presence pulse and a 40-bit payload+checksum frame.
module dht11_responder
    import dht_pkg::*;
#(
    parameter int TICKS_PER_US = DHT_TICKS_PER_US,
    parameter int START_MIN_US = DHT_START_MIN_US,
    parameter int RESP_WAIT_US = DHT_RESP_WAIT_US,
    parameter int RESP_LOW_US  = DHT_RESP_LOW_US,
    parameter int RESP_HIGH_US = DHT_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DHT_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DHT_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DHT_BIT1_HIGH_US
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       read_i,
    input  logic [7:0] hum_int_i,
    input  logic [7:0] hum_dec_i,
    input  logic [7:0] temp_int_i,
    input  logic [7:0] temp_dec_i,
    output logic       dir_o,
    output logic       send_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef logic [DHT_CNT_W-1:0] cnt_t;

    // The IDLE cycle that sees the first low is not counted in HOST_LOW,
    // hence the -1 on the start threshold. Phase loads are duration-1.
    localparam cnt_t C_START  = cnt_t'(START_MIN_US * TICKS_PER_US - 1);
    localparam cnt_t C_WAIT   = cnt_t'(RESP_WAIT_US * TICKS_PER_US - 1);
    localparam cnt_t C_RLOW   = cnt_t'(RESP_LOW_US  * TICKS_PER_US - 1);
    localparam cnt_t C_RHIGH  = cnt_t'(RESP_HIGH_US * TICKS_PER_US - 1);
    localparam cnt_t C_BLOW   = cnt_t'(BIT_LOW_US   * TICKS_PER_US - 1);
    localparam cnt_t C_B0     = cnt_t'(BIT0_HIGH_US * TICKS_PER_US - 1);
    localparam cnt_t C_B1     = cnt_t'(BIT1_HIGH_US * TICKS_PER_US - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam logic [5:0] LAST_BIT = 6'(DHT_FRAME_W - 1);

    logic                   rd;
    dht_state_t             state_q;
    cnt_t                   cnt_q;
    logic [DHT_FRAME_W-1:0] sr_q;
    logic [5:0]             bit_q;
    logic                   dir_q, busy_q, done_q;

    dht_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (read_i),
        .q_o   (rd)
    );

    assign dir_o  = dir_q;
    assign send_o = 1'b0;
    assign busy_o = busy_q;
    assign done_o = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rd) begin
                        state_q <= ST_HOST_LOW;
                        cnt_q   <= '0;
                    end
                end
                ST_HOST_LOW: begin
                    if (!rd) begin
                        if (~&cnt_q) cnt_q <= cnt_q + CNT_ONE;
                    end else if (cnt_q >= C_START) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= C_WAIT;
                        sr_q    <= dht_frame(hum_int_i, hum_dec_i, temp_int_i, temp_dec_i);
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        case (state_q)
                            ST_WAIT: begin
                                state_q <= ST_RESP_LOW;
                                cnt_q   <= C_RLOW;
                                dir_q   <= 1'b1;
                            end
                            ST_RESP_LOW: begin
                                state_q <= ST_RESP_HIGH;
                                cnt_q   <= C_RHIGH;
                                dir_q   <= 1'b0;
                            end
                            ST_RESP_HIGH: begin
                                state_q <= ST_BIT_LOW;
                                cnt_q   <= C_BLOW;
                                dir_q   <= 1'b1;
                            end
                            ST_BIT_LOW: begin
                                state_q <= ST_BIT_HIGH;
                                cnt_q   <= sr_q[DHT_FRAME_W-1] ? C_B1 : C_B0;
                                dir_q   <= 1'b0;
                            end
                            ST_BIT_HIGH: begin
                                state_q <= (bit_q == LAST_BIT) ? ST_EOF_LOW : ST_BIT_LOW;
                                cnt_q   <= C_BLOW;
                                sr_q    <= sr_q << 1;
                                bit_q   <= bit_q + 6'd1;
                                dir_q   <= 1'b1;
                            end
                            ST_EOF_LOW: begin
                                state_q <= ST_IDLE;
                                dir_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                                dir_q   <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: drives host start pulses on a pulled-up line and checks
// the responder's per-cycle DIR/BUSY/DONE trace and decoded frame bytes.
module tb_dht11_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic       read;
    logic [7:0] hi = '0, hd = '0, ti = '0, td = '0;
    logic       dir, send, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign read = dir ? send : ~host_low;

    dht11_responder #(
        .TICKS_PER_US (1),
        .START_MIN_US (100)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .read_i     (read),
        .hum_int_i  (hi),
        .hum_dec_i  (hd),
        .temp_int_i (ti),
        .temp_dec_i (td),
        .dir_o      (dir),
        .send_o     (send),
        .busy_o     (busy),
        .done_o     (done)
    );

    typedef struct {
        string      name;
        int         n_low;
        logic [7:0] a, b, c, d;
        bit         accept;
        logic [7:0] chk;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic seg(input logic [2:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic host_pulse(input int n);
        @(negedge clk);
        host_low = 1'b1;
        repeat (n) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Expected per-cycle {dir,busy,done} after the host releases the line:
    // 2 sync cycles, 30 wait, 80/80 presence, 40 x (50 low + 27/70 high),
    // 50 end-of-frame low, one DONE cycle, then quiet.
    task automatic build_model(input logic [39:0] fr, input bit accept);
        exp_q.delete();
        if (!accept) begin
            seg(3'b000, 200);
        end else begin
            seg(3'b000, 2);
            seg(3'b010, 30);
            seg(3'b110, 80);
            seg(3'b010, 80);
            for (int i = 39; i >= 0; i--) begin
                seg(3'b110, 50);
                seg(3'b010, fr[i] ? 70 : 27);
            end
            seg(3'b110, 50);
            seg(3'b001, 1);
            seg(3'b000, 4);
        end
    endtask

    task automatic run_frame(input string tag, input int n_low,
                             input logic [7:0] a, b, c, d, input bit accept,
                             input logic [7:0] chk, input int mod_idx, input int cont_idx);
        logic [39:0] fr, dec;
        int bad, first, run, hruns, nbit, ndone;
        hi = a; hd = b; ti = c; td = d;
        fr = {a, b, c, d, 8'(a + b + c + d)};
        build_model(fr, accept);
        got_q.delete();
        host_pulse(n_low);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got_q.push_back({dir, busy, done});
            if (i == mod_idx) hi = 8'hAA;
            if (i == cont_idx) host_low = 1'b1;
            if (i == cont_idx + 20) host_low = 1'b0;
        end
        host_low = 1'b0;
        bad = 0; first = -1; ndone = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
            if (got_q[i][0]) ndone++;
        end
        check($sformatf("%s trace mismatches (first at %0d)", tag, first), bad, 0);
        check({tag, " done pulses"}, ndone, accept ? 1 : 0);
        if (accept) begin
            run = 0; hruns = 0; nbit = 0; dec = '0;
            foreach (got_q[i]) begin
                if (got_q[i][1] && !got_q[i][2]) begin
                    run++;
                end else begin
                    if (run > 0) begin
                        hruns++;
                        if (hruns > 2 && nbit < 40) begin
                            dec = {dec[38:0], 1'(run > 48)};
                            nbit++;
                        end
                    end
                    run = 0;
                end
            end
            check({tag, " bit count"}, nbit, 40);
            for (int k = 0; k < 5; k++)
                check($sformatf("%s byte%0d", tag, k), dec[39-8*k -: 8], fr[39-8*k -: 8]);
            check({tag, " checksum const"}, dec[7:0], chk);
        end
    endtask

    initial begin
        logic [39:0] fr;
        logic [7:0]  a, b, c, d;
        int          idx, ndone;

        repeat (3) @(negedge clk);
        check("reset dir", dir, 0);
        check("reset send", send, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle busy", busy, 0);

        vecs.push_back('{"nominal", 120, 8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 8'h55});
        vecs.push_back('{"wrap",    130, 8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1, 8'h01});
        vecs.push_back('{"low99",    99, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 8'h00});
        vecs.push_back('{"low100",  100, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 8'h14});
        vecs.push_back('{"glitch",    1, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 8'h00});
        foreach (vecs[i])
            run_frame(vecs[i].name, vecs[i].n_low, vecs[i].a, vecs[i].b, vecs[i].c,
                      vecs[i].d, vecs[i].accept, vecs[i].chk, -1, -1);

        for (int r = 0; r < 3; r++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            run_frame($sformatf("rand%0d", r), int'($urandom_range(100, 300)),
                      a, b, c, d, 1'b1, 8'(a + b + c + d), -1, -1);
        end

        // HUM_INT changes during bit 3; host pulls low during presence high.
        run_frame("midchg", 150, 8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 8'h55, 400, 120);

        hi = 8'h37; hd = 8'h00; ti = 8'h19; td = 8'h05;
        fr = {hi, hd, ti, td, 8'h55};
        idx = 2 + 30 + 160 + 10;
        for (int i = 39; i > 19; i--) idx += 50 + (fr[i] ? 70 : 27);
        host_pulse(120);
        repeat (idx + 1) @(negedge clk);
        check("pre-reset dir", dir, 1);
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async reset dir", dir, 0);
        check("async reset busy", busy, 0);
        ndone = 0;
        repeat (2) @(negedge clk) ndone += int'(done);
        rst = 1'b0;
        repeat (20) @(negedge clk) ndone += int'(done);
        check("reset no done", ndone, 0);
        check("post-reset busy", busy, 0);

        run_frame("after_reset", 110, 8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 8'h55, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
